multicycle_control: RTL and testbench

Multi-cycle sequencer that directly feeds the 16-bit ALU. It owns PC and IR, fetches via a req/ready memory handshake, decodes the 4-bit opcode, and drives aluControl, register addresses, the immediate and datapath selects. It consumes the ALU zero flag to resolve BEQ, and sits between the memory interface and the register-file/ALU datapath.

---
 rtl/isa_pkg.sv | 64 ++++++
 rtl/instruction_decoder.sv | 58 +++++
 rtl/multicycle_control.sv | 169 ++++++++++++++++
 tb/tb_multicycle_control.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// ISA definitions shared by the multicycle sequencer and its instruction decoder:
// opcodes, ALU function codes, FSM states and instruction field positions.
package isa_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_SLT  = 4'h4,
        OP_ADDI = 4'h5,
        OP_LUI  = 4'h6,
        OP_LW   = 4'h7,
        OP_SW   = 4'h8,
        OP_BEQ  = 4'h9,
        OP_JMP  = 4'hA,
        OP_HALT = 4'hF
    } opcode_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_LUI = 3'b101;

    typedef enum logic [3:0] {
        ST_RESET,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM_READ,
        ST_MEM_WRITE,
        ST_WRITEBACK,
        ST_HALT,
        ST_TRAP
    } state_e;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int RD_MSB = 11;
    localparam int RD_LSB = 9;
    localparam int RS_MSB = 8;
    localparam int RS_LSB = 6;
    localparam int RT_MSB = 5;
    localparam int RT_LSB = 3;

    typedef struct packed {
        logic is_rtype;
        logic is_addi;
        logic is_lui;
        logic is_lw;
        logic is_sw;
        logic is_beq;
        logic is_jmp;
        logic is_halt;
        logic is_illegal;
    } instr_class_t;

    function automatic logic [15:0] sext6(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Combinational decode of the instruction register into register addresses,
// immediate, ALU controls and instruction-class flags.
module instruction_decoder
    import isa_pkg::*;
(
    input  logic [15:0]  ir_i,
    output logic [2:0]   read_addr1_o,
    output logic [2:0]   read_addr2_o,
    output logic [2:0]   write_addr_o,
    output logic [15:0]  imm16_o,
    output logic [2:0]   alu_control_o,
    output logic         alu_src_b_o,
    output instr_class_t cls_o
);

    opcode_e op;

    always_comb begin
        op            = opcode_e'(ir_i[OP_MSB:OP_LSB]);
        read_addr1_o  = ir_i[RS_MSB:RS_LSB];
        read_addr2_o  = ir_i[RT_MSB:RT_LSB];
        write_addr_o  = ir_i[RD_MSB:RD_LSB];
        imm16_o       = sext6(ir_i[5:0]);
        alu_control_o = ALU_ADD;
        alu_src_b_o   = 1'b0;
        cls_o         = '0;

        case (op)
            OP_ADD:  begin cls_o.is_rtype = 1'b1; alu_control_o = ALU_ADD; end
            OP_SUB:  begin cls_o.is_rtype = 1'b1; alu_control_o = ALU_SUB; end
            OP_AND:  begin cls_o.is_rtype = 1'b1; alu_control_o = ALU_AND; end
            OP_OR:   begin cls_o.is_rtype = 1'b1; alu_control_o = ALU_OR;  end
            OP_SLT:  begin cls_o.is_rtype = 1'b1; alu_control_o = ALU_SLT; end
            OP_ADDI: begin cls_o.is_addi  = 1'b1; alu_src_b_o = 1'b1; end
            OP_LUI: begin
                cls_o.is_lui  = 1'b1;
                alu_control_o = ALU_LUI;
                alu_src_b_o   = 1'b1;
                imm16_o       = {8'h00, ir_i[7:0]};
            end
            OP_LW:   begin cls_o.is_lw = 1'b1; alu_src_b_o = 1'b1; end
            OP_SW: begin
                cls_o.is_sw  = 1'b1;
                alu_src_b_o  = 1'b1;
                read_addr2_o = ir_i[RD_MSB:RD_LSB];
            end
            OP_BEQ: begin
                cls_o.is_beq  = 1'b1;
                alu_control_o = ALU_SUB;
                read_addr2_o  = ir_i[RD_MSB:RD_LSB];
            end
            OP_JMP:  cls_o.is_jmp  = 1'b1;
            OP_HALT: cls_o.is_halt = 1'b1;
            default: cls_o.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: owns PC/IR, runs the fetch/decode/execute FSM with a
// req/ready memory handshake, memory timeout and sticky fault flags.
module multicycle_control
    import isa_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] memRdata,
    input  logic        memReady,
    input  logic        zero,
    output logic        memReq,
    output logic        memWrite,
    output logic        memAddrSel,
    output logic [15:0] pc,
    output logic [2:0]  readAddr1,
    output logic [2:0]  readAddr2,
    output logic [2:0]  writeAddr,
    output logic        regWrite,
    output logic [15:0] imm16,
    output logic        aluSrcB,
    output logic [2:0]  aluControl,
    output logic        wbSel,
    output logic        halted,
    output logic        illegal,
    output logic        busError
);

    localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

    state_e       state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  ir_q, ir_d;
    logic [15:0]  tmo_cnt_q, tmo_cnt_d;
    logic         illegal_q, illegal_d;
    logic         bus_error_q, bus_error_d;
    logic         mem_req_q, mem_write_q, mem_addr_sel_q;
    logic         reg_write_q, wb_sel_q, halted_q;
    logic         tmo_hit;
    instr_class_t cls;

    instruction_decoder u_decoder (
        .ir_i          (ir_q),
        .read_addr1_o  (readAddr1),
        .read_addr2_o  (readAddr2),
        .write_addr_o  (writeAddr),
        .imm16_o       (imm16),
        .alu_control_o (aluControl),
        .alu_src_b_o   (aluSrcB),
        .cls_o         (cls)
    );

    // A ready in the limit cycle still completes the transfer.
    assign tmo_hit = (MEM_TIMEOUT != 0) && !memReady && (tmo_cnt_q == TMO_LAST);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        tmo_cnt_d   = tmo_cnt_q;
        illegal_d   = illegal_q;
        bus_error_d = bus_error_q;

        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                if (memReady) begin
                    ir_d    = memRdata;
                    pc_d    = pc_q + 16'd1;
                    state_d = ST_DECODE;
                end else if (tmo_hit) begin
                    bus_error_d = 1'b1;
                    state_d     = ST_TRAP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            ST_DECODE: begin
                if (cls.is_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = ST_TRAP;
                end else if (cls.is_halt) begin
                    state_d = ST_HALT;
                end else if (cls.is_jmp) begin
                    pc_d    = {pc_q[15:12], ir_q[11:0]};
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (cls.is_lw) begin
                    state_d = ST_MEM_READ;
                end else if (cls.is_sw) begin
                    state_d = ST_MEM_WRITE;
                end else if (cls.is_beq) begin
                    if (zero) pc_d = pc_q + imm16;
                    state_d = ST_FETCH;
                end else if (cls.is_rtype || cls.is_addi || cls.is_lui) begin
                    state_d = ST_WRITEBACK;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM_READ, ST_MEM_WRITE: begin
                if (memReady) begin
                    state_d = (state_q == ST_MEM_READ) ? ST_WRITEBACK : ST_FETCH;
                end else if (tmo_hit) begin
                    bus_error_d = 1'b1;
                    state_d     = ST_TRAP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            ST_WRITEBACK: state_d = ST_FETCH;
            ST_HALT:      state_d = ST_HALT;
            ST_TRAP:      state_d = ST_TRAP;
            default:      state_d = ST_TRAP;
        endcase

        if ((state_d inside {ST_FETCH, ST_MEM_READ, ST_MEM_WRITE}) && (state_d != state_q)) begin
            tmo_cnt_d = 16'd0;
        end
    end

    // Handshake and control outputs are registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_RESET;
            pc_q           <= RESET_PC;
            ir_q           <= 16'h0000;
            tmo_cnt_q      <= 16'd0;
            illegal_q      <= 1'b0;
            bus_error_q    <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_addr_sel_q <= 1'b0;
            reg_write_q    <= 1'b0;
            wb_sel_q       <= 1'b0;
            halted_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            ir_q           <= ir_d;
            tmo_cnt_q      <= tmo_cnt_d;
            illegal_q      <= illegal_d;
            bus_error_q    <= bus_error_d;
            mem_req_q      <= state_d inside {ST_FETCH, ST_MEM_READ, ST_MEM_WRITE};
            mem_write_q    <= (state_d == ST_MEM_WRITE);
            mem_addr_sel_q <= state_d inside {ST_MEM_READ, ST_MEM_WRITE};
            reg_write_q    <= (state_d == ST_WRITEBACK);
            wb_sel_q       <= (state_d == ST_WRITEBACK) && cls.is_lw;
            halted_q       <= state_d inside {ST_HALT, ST_TRAP};
        end
    end

    assign memReq     = mem_req_q;
    assign memWrite   = mem_write_q;
    assign memAddrSel = mem_addr_sel_q;
    assign pc         = pc_q;
    assign regWrite   = reg_write_q;
    assign wbSel      = wb_sel_q;
    assign halted     = halted_q;
    assign illegal    = illegal_q;
    assign busError   = bus_error_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: expectations are queued when each
// instruction is presented and popped as the FSM reaches the matching state.
module tb_multicycle_control;

    logic        clk;
    logic        reset;
    logic [15:0] memRdata;
    logic        memReady;
    logic        zero;
    logic        memReq, memWrite, memAddrSel, regWrite, aluSrcB, wbSel;
    logic        halted, illegal, busError;
    logic [15:0] pc, imm16;
    logic [2:0]  readAddr1, readAddr2, writeAddr, aluControl;

    int vectors     = 0;
    int miscompares = 0;

    string       tag_q[$];
    logic [15:0] exp_q[$];

    multicycle_control #(
        .RESET_PC    (16'h0000),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .memRdata   (memRdata),
        .memReady   (memReady),
        .zero       (zero),
        .memReq     (memReq),
        .memWrite   (memWrite),
        .memAddrSel (memAddrSel),
        .pc         (pc),
        .readAddr1  (readAddr1),
        .readAddr2  (readAddr2),
        .writeAddr  (writeAddr),
        .regWrite   (regWrite),
        .imm16      (imm16),
        .aluSrcB    (aluSrcB),
        .aluControl (aluControl),
        .wbSel      (wbSel),
        .halted     (halted),
        .illegal    (illegal),
        .busError   (busError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input string tag, input logic [15:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic pop_check(input logic [15:0] obs);
        string       tag;
        logic [15:0] expv;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_underflow: observed %h, expected nothing queued", obs);
        end else begin
            tag  = tag_q.pop_front();
            expv = exp_q.pop_front();
            assert (obs === expv) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", tag, obs, expv);
            end
        end
    endtask

    task automatic fetch(input logic [15:0] instr);
        memRdata = instr;
        memReady = 1'b1;
        step();
        memReady = 1'b0;
        memRdata = 16'h0000;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        reset    = 1'b1;
        memRdata = 16'h0000;
        memReady = 1'b0;
        zero     = 1'b0;

        // Reset state
        @(negedge clk);
        push("rst_memReq", 16'h0); push("rst_pc", 16'h0000); push("rst_halted", 16'h0);
        push("rst_alu", 16'h0); push("rst_imm", 16'h0000);
        pop_check(16'(memReq)); pop_check(pc); pop_check(16'(halted));
        pop_check(16'(aluControl)); pop_check(imm16);
        step();
        reset = 1'b0;
        push("rel_reset_cycle_memReq", 16'h0);
        pop_check(16'(memReq));
        step();
        push("first_fetch_memReq", 16'h1); push("first_fetch_asel", 16'h0);
        pop_check(16'(memReq)); pop_check(16'(memAddrSel));

        // Asynchronous reset in the middle of a fetch handshake
        step();
        #2 reset = 1'b1;
        #1;
        push("midrst_memReq", 16'h0); push("midrst_pc", 16'h0000);
        pop_check(16'(memReq)); pop_check(pc);
        @(negedge clk);
        reset = 1'b0;
        push("midrst_reset_cycle_memReq", 16'h0);
        pop_check(16'(memReq));
        step();
        push("midrst_fetch_memReq", 16'h1); push("midrst_fetch_asel", 16'h0);
        pop_check(16'(memReq)); pop_check(16'(memAddrSel));

        // ADD r1 = r2 + r3 at pc 0000
        push("add_alu", 16'h0); push("add_ra1", 16'h2); push("add_ra2", 16'h3); push("add_srcb", 16'h0);
        push("add_we", 16'h1); push("add_wa", 16'h1); push("add_wbsel", 16'h0);
        push("add_next_memReq", 16'h1); push("add_pc", 16'h0001);
        fetch(16'h0298);
        step();
        pop_check(16'(aluControl)); pop_check(16'(readAddr1)); pop_check(16'(readAddr2)); pop_check(16'(aluSrcB));
        step();
        pop_check(16'(regWrite)); pop_check(16'(writeAddr)); pop_check(16'(wbSel));
        step();
        pop_check(16'(memReq)); pop_check(pc);

        // LUI r3 = 0x00A5 at pc 0001
        push("lui_alu", 16'h5); push("lui_srcb", 16'h1); push("lui_imm", 16'h00A5); push("lui_wa", 16'h3);
        push("lui_we", 16'h1); push("lui_pc", 16'h0002);
        fetch(16'h66A5);
        step();
        pop_check(16'(aluControl)); pop_check(16'(aluSrcB)); pop_check(imm16); pop_check(16'(writeAddr));
        step();
        pop_check(16'(regWrite));
        step();
        pop_check(pc);

        // SW r5 -> [r2+3] at pc 0002, memReady after 3 wait cycles
        push("sw_alu", 16'h0); push("sw_srcb", 16'h1); push("sw_imm", 16'h0003); push("sw_ra2", 16'h5);
        for (int k = 0; k < 4; k++) begin
            push($sformatf("sw_req_%0d", k), 16'h1); push($sformatf("sw_wr_%0d", k), 16'h1);
            push($sformatf("sw_asel_%0d", k), 16'h1); push($sformatf("sw_we_%0d", k), 16'h0);
        end
        push("sw_fetch_memReq", 16'h1); push("sw_fetch_wr", 16'h0); push("sw_fetch_asel", 16'h0);
        push("sw_fetch_we", 16'h0); push("sw_pc", 16'h0003);
        fetch(16'h8A83);
        step();
        pop_check(16'(aluControl)); pop_check(16'(aluSrcB)); pop_check(imm16); pop_check(16'(readAddr2));
        step();
        for (int k = 0; k < 4; k++) begin
            pop_check(16'(memReq)); pop_check(16'(memWrite)); pop_check(16'(memAddrSel)); pop_check(16'(regWrite));
            memReady = (k == 3);
            step();
        end
        memReady = 1'b0;
        pop_check(16'(memReq)); pop_check(16'(memWrite)); pop_check(16'(memAddrSel));
        pop_check(16'(regWrite)); pop_check(pc);

        // LW r7 <- [r1-4] at pc 0003, memReady after 3 wait cycles
        push("lw_imm", 16'hFFFC); push("lw_alu", 16'h0); push("lw_srcb", 16'h1); push("lw_ra1", 16'h1);
        for (int k = 0; k < 4; k++) begin
            push($sformatf("lw_req_%0d", k), 16'h1); push($sformatf("lw_wr_%0d", k), 16'h0);
            push($sformatf("lw_asel_%0d", k), 16'h1);
        end
        push("lw_we", 16'h1); push("lw_wbsel", 16'h1); push("lw_wa", 16'h7); push("lw_pc", 16'h0004);
        fetch(16'h7E7C);
        step();
        pop_check(imm16); pop_check(16'(aluControl)); pop_check(16'(aluSrcB)); pop_check(16'(readAddr1));
        step();
        for (int k = 0; k < 4; k++) begin
            pop_check(16'(memReq)); pop_check(16'(memWrite)); pop_check(16'(memAddrSel));
            memReady = (k == 3);
            memRdata = 16'hBEEF;
            step();
        end
        memReady = 1'b0;
        memRdata = 16'h0000;
        pop_check(16'(regWrite)); pop_check(16'(wbSel)); pop_check(16'(writeAddr));
        step();
        pop_check(pc);

        // JMP 0x123 at pc 0004, then JMP 0x005 at pc 0123
        push("jmp1_decode_pc", 16'h0005); push("jmp1_memReq", 16'h1); push("jmp1_pc", 16'h0123);
        fetch(16'hA123);
        pop_check(pc);
        step();
        pop_check(16'(memReq)); pop_check(pc);
        push("jmp2_pc", 16'h0005);
        fetch(16'hA005);
        step();
        pop_check(pc);

        // BEQ taken at pc 0005: branch target 0006 + (-2)
        zero = 1'b1;
        push("beq_t_alu", 16'h1); push("beq_t_srcb", 16'h0); push("beq_t_imm", 16'hFFFE);
        push("beq_t_ra1", 16'h2); push("beq_t_ra2", 16'h1); push("beq_t_memReq", 16'h1); push("beq_t_pc", 16'h0004);
        fetch(16'h92BE);
        step();
        pop_check(16'(aluControl)); pop_check(16'(aluSrcB)); pop_check(imm16);
        pop_check(16'(readAddr1)); pop_check(16'(readAddr2));
        step();
        pop_check(16'(memReq)); pop_check(pc);
        zero = 1'b0;

        // Back to 0005 and take the fall-through path
        fetch(16'hA005);
        step();
        push("beq_nt_memReq", 16'h1); push("beq_nt_pc", 16'h0006);
        fetch(16'h92BE);
        step();
        step();
        pop_check(16'(memReq)); pop_check(pc);

        // Illegal opcode at pc 0006: trap is sticky and ignores memReady
        for (int k = 0; k < 3; k++) begin
            push($sformatf("ill_halted_%0d", k), 16'h1); push($sformatf("ill_flag_%0d", k), 16'h1);
            push($sformatf("ill_buserr_%0d", k), 16'h0); push($sformatf("ill_memReq_%0d", k), 16'h0);
        end
        push("ill_pc", 16'h0007);
        fetch(16'hB000);
        step();
        for (int k = 0; k < 3; k++) begin
            pop_check(16'(halted)); pop_check(16'(illegal)); pop_check(16'(busError)); pop_check(16'(memReq));
            memReady = 1'b1;
            step();
        end
        memReady = 1'b0;
        pop_check(pc);

        // HALT after reset clears the trap flags
        pulse_reset();
        push("halt_fetch_pc", 16'h0000); push("halt_fetch_illegal", 16'h0);
        push("halt_halted", 16'h1); push("halt_illegal", 16'h0); push("halt_memReq", 16'h0);
        pop_check(pc); pop_check(16'(illegal));
        fetch(16'hF000);
        step();
        pop_check(16'(halted)); pop_check(16'(illegal)); pop_check(16'(memReq));

        // Fetch timeout: memReq high for exactly 4 cycles, then bus error trap
        pulse_reset();
        for (int k = 0; k < 4; k++) push($sformatf("tmo_memReq_%0d", k), 16'h1);
        push("tmo_trap_memReq", 16'h0); push("tmo_buserr", 16'h1); push("tmo_halted", 16'h1); push("tmo_illegal", 16'h0);
        for (int k = 0; k < 4; k++) begin
            pop_check(16'(memReq));
            step();
        end
        pop_check(16'(memReq)); pop_check(16'(busError)); pop_check(16'(halted)); pop_check(16'(illegal));

        vectors++;
        assert (exp_q.size() == 0) else begin
            miscompares++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
